// File: rtl/otter_pc_pkg.sv
// Shared types for the OTTER program-counter unit: next-PC source codes and sequencer states.
package otter_pc_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        JALR   = 3'd1,
        BRANCH = 3'd2,
        JAL    = 3'd3,
        TRAP   = 3'd4,
        MRET   = 3'd5
    } pc_sel_t;

    // State literals carry a prefix so they cannot collide with the TRAP source code.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd5);
    endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder: PC + STEP, wrapping modulo 2^PC_W.
module pc_incr #(
    parameter int PC_W = 32,
    parameter int STEP = 4
) (
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus
);

    assign pc_plus = pc + PC_W'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// OTTER fetch-stage program counter: next-PC select, alignment trap, BOOT/RUN/TRAP sequencing.
// Optional redirect-history buffer enabled with `define PC_HIST_EN.
module pc_sequencer
    import otter_pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter int              ALIGN_B   = 2,
    parameter int              HIST_D    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic [2:0]                pc_sel,
    input  logic [PC_W-1:0]           jalr_t,
    input  logic [PC_W-1:0]           branch_t,
    input  logic [PC_W-1:0]           jal_t,
    input  logic [PC_W-1:0]           mtvec,
    input  logic [PC_W-1:0]           mepc,
    output logic [PC_W-1:0]           pc,
    output logic [PC_W-1:0]           pc_plus,
    output logic                      pc_valid,
    output logic                      misalign,
    output logic [PC_W-1:0]           bad_addr
`ifdef PC_HIST_EN
    ,
    input  logic [$clog2(HIST_D)-1:0] hist_idx,
    output logic [PC_W-1:0]           hist_pc
`endif
);

    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'((64'd1 << ALIGN_B) - 64'd1);

    pc_state_t       state, next_state;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] bad_addr_next;
    logic            misalign_next;
    logic            tgt_misaligned;

    pc_incr #(
        .PC_W (PC_W),
        .STEP (STEP)
    ) u_incr (
        .pc      (pc),
        .pc_plus (pc_plus)
    );

    // Codes 6 and 7 fall through to the sequential address.
    always_comb begin
        target = pc_plus;
        case (pc_sel_t'(pc_sel))
            JALR:    target = jalr_t & ~PC_W'(1);
            BRANCH:  target = branch_t;
            JAL:     target = jal_t;
            TRAP:    target = mtvec;
            MRET:    target = mepc;
            default: target = pc_plus;
        endcase
    end

    assign tgt_misaligned = is_redirect(pc_sel) && ((target & ALIGN_MASK) != '0);
    assign pc_valid       = (state == ST_RUN);

    always_comb begin
        next_state    = state;
        pc_next       = pc;
        misalign_next = 1'b0;
        bad_addr_next = bad_addr;
        case (state)
            ST_BOOT: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (tgt_misaligned) begin
                        misalign_next = 1'b1;
                        bad_addr_next = target;
                        next_state    = ST_TRAP;
                    end else begin
                        pc_next = target;
                    end
                end
            end
            // The trap vector is force-aligned so a bad MTVEC can never re-trap.
            ST_TRAP: begin
                pc_next    = mtvec & ~ALIGN_MASK;
                next_state = ST_RUN;
            end
            default: begin
                next_state = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_VEC;
            misalign <= 1'b0;
            bad_addr <= '0;
        end else begin
            state    <= next_state;
            pc       <= pc_next;
            misalign <= misalign_next;
            bad_addr <= bad_addr_next;
        end
    end

`ifdef PC_HIST_EN
    localparam int HIST_W = $clog2(HIST_D);

    logic [PC_W-1:0]   hist_mem [HIST_D];
    logic [HIST_W-1:0] wr_ptr;
    logic              hist_we;

    // Only redirects that actually move the PC are logged, with their source address.
    assign hist_we = (state == ST_RUN) && !stall && is_redirect(pc_sel) && !tgt_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < HIST_D; i++) begin
                hist_mem[i] <= '0;
            end
        end else if (hist_we) begin
            hist_mem[wr_ptr] <= pc;
            wr_ptr           <= wr_ptr + HIST_W'(1);
        end
    end

    assign hist_pc = hist_mem[wr_ptr - HIST_W'(1) - hist_idx];
`else
    if (HIST_D < 1) begin : g_no_hist
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic vs a reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  pcSel = 3'd0;
    logic [31:0] jalrT = '0, branchT = '0, jalT = '0, mtvecV = '0, mepcV = '0;
    logic [31:0] pc, pcPlus, badAddr;
    logic        pcValid, misalign;
`ifdef PC_HIST_EN
    logic [1:0]  histIdx = '0;
    logic [31:0] histPc;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mPc, mBad;
    bit          mBoot, mTrap, mMis;
    logic [31:0] mHist[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .pc_sel   (pcSel),
        .jalr_t   (jalrT),
        .branch_t (branchT),
        .jal_t    (jalT),
        .mtvec    (mtvecV),
        .mepc     (mepcV),
        .pc       (pc),
        .pc_plus  (pcPlus),
        .pc_valid (pcValid),
        .misalign (misalign),
        .bad_addr (badAddr)
`ifdef PC_HIST_EN
        ,
        .hist_idx (histIdx),
        .hist_pc  (histPc)
`endif
    );

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPc   = 32'h0;
        mBoot = 1'b1;
        mTrap = 1'b0;
        mMis  = 1'b0;
        mBad  = 32'h0;
        mHist.delete();
    endtask

    // One clock edge of the specified behaviour, using the inputs presented before the edge.
    task automatic modelStep(input bit s, input logic [2:0] sel);
        logic [31:0] t;
        bit          redirect;
        mMis = 1'b0;
        if (mBoot) begin
            mBoot = 1'b0;
        end else if (mTrap) begin
            mPc   = mtvecV - (mtvecV % 32'd4);
            mTrap = 1'b0;
        end else if (!s) begin
            redirect = (sel >= 3'd1) && (sel <= 3'd5);
            case (sel)
                3'd1:    t = jalrT - (jalrT % 32'd2);
                3'd2:    t = branchT;
                3'd3:    t = jalT;
                3'd4:    t = mtvecV;
                3'd5:    t = mepcV;
                default: t = mPc + 32'd4;
            endcase
            if (redirect && (t % 32'd4) != 0) begin
                mMis  = 1'b1;
                mBad  = t;
                mTrap = 1'b1;
            end else begin
                if (redirect) begin
                    mHist.push_front(mPc);
                    if (mHist.size() > 4) void'(mHist.pop_back());
                end
                mPc = t;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_pc"}, pc, mPc);
        checkOutput({tag, "_pcplus"}, pcPlus, mPc + 32'd4);
        checkOutput({tag, "_valid"}, {31'd0, pcValid}, {31'd0, !(mBoot || mTrap)});
        checkOutput({tag, "_misalign"}, {31'd0, misalign}, {31'd0, mMis});
        checkOutput({tag, "_badaddr"}, badAddr, mBad);
`ifdef PC_HIST_EN
        for (int i = 0; i < 4; i++) begin
            histIdx = 2'(i);
            #1;
            checkOutput($sformatf("%s_hist%0d", tag, i), histPc,
                        (i < mHist.size()) ? mHist[i] : 32'h0);
        end
`endif
    endtask

    task automatic applyStimulus(input string tag, input bit s, input logic [2:0] sel);
        stall = s;
        pcSel = sel;
        modelStep(s, sel);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkAll("rst_rel");
    endtask

    initial begin
        modelReset();
        $display("[TB] starting pc_sequencer test");

        // Reset, BOOT cycle, then sequential fetch 0,4,8,C
        doReset();
        checkOutput("t1_pc0", pc, 32'h0);
        applyStimulus("t1_boot", 1'b1, 3'd2);
        for (int i = 0; i < 3; i++) applyStimulus("t1_seq", 1'b0, 3'd0);
        checkOutput("t1_pcC", pc, 32'hC);

        // Branch then stall for two cycles
        jalT = 32'h100;
        applyStimulus("t2_jal", 1'b0, 3'd3);
        branchT = 32'h200;
        applyStimulus("t2_br", 1'b0, 3'd2);
        checkOutput("t2_pc200", pc, 32'h200);
        branchT = 32'h400;
        applyStimulus("t2_st1", 1'b1, 3'd2);
        applyStimulus("t2_st2", 1'b1, 3'd2);
        checkOutput("t2_hold", pc, 32'h200);

        // Misaligned JAL traps to MTVEC
        jalT = 32'h202; mtvecV = 32'h84;
        applyStimulus("t3_jal", 1'b0, 3'd3);
        checkOutput("t3_mis", {31'd0, misalign}, 32'd1);
        checkOutput("t3_bad", badAddr, 32'h202);
        applyStimulus("t3_trap", 1'b1, 3'd0);
        checkOutput("t3_vec", pc, 32'h84);

        // JALR clears bit 0; SEQ wraps at the top of the address space
        jalrT = 32'h301;
        applyStimulus("t4_jalr", 1'b0, 3'd1);
        checkOutput("t4_pc300", pc, 32'h300);
        branchT = 32'hFFFF_FFFC;
        applyStimulus("t4_br", 1'b0, 3'd2);
        applyStimulus("t4_wrap", 1'b0, 3'd0);
        checkOutput("t4_pc0", pc, 32'h0);
        checkOutput("t4_plus", pcPlus, 32'h4);

        // Redirects from 0x10..0x50 populate history newest-first
        branchT = 32'h10;
        applyStimulus("t5_go", 1'b0, 3'd2);
        for (int i = 1; i <= 5; i++) begin
            jalT = 32'(i * 16 + 16);
            applyStimulus("t5_hist", 1'b0, 3'd3);
        end

        // Stalled TRAP selection is ignored until STALL drops
        mtvecV = 32'h80;
        applyStimulus("t6_st", 1'b1, 3'd4);
        applyStimulus("t6_go", 1'b0, 3'd4);
        checkOutput("t6_pc80", pc, 32'h80);

        // Misaligned MTVEC is force-aligned; reset during TRAP cancels it
        mtvecV = 32'h83; jalT = 32'h1;
        applyStimulus("t7_jal", 1'b0, 3'd3);
        applyStimulus("t7_trap", 1'b0, 3'd0);
        checkOutput("t7_vec", pc, 32'h80);
        jalT = 32'h6;
        applyStimulus("t7_jal2", 1'b0, 3'd3);
        doReset();
        applyStimulus("t7_boot", 1'b0, 3'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            jalrT   = $urandom;
            branchT = $urandom;
            jalT    = $urandom;
            mtvecV  = $urandom;
            mepcV   = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                jalrT[1]   = 1'b0;
                branchT[1:0] = 2'b00;
                jalT[1:0]  = 2'b00;
                mtvecV[1:0] = 2'b00;
                mepcV[1:0] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) branchT = 32'hFFFF_FFF8;
            if ($urandom_range(0, 99) == 0) doReset();
            applyStimulus("rnd", ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
